// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Reads back a multiplexed, active-low 4-digit 7-segment drive and rebuilds the
// hex value being shown. A digit is only captured after its {anode,seg}
// pattern has been seen unchanged and legal for SETTLE consecutive clocks. This
// keeps scan transitions and glitches from ever reaching the outputs.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high; clears all state
//   anode[3:0]  digit select, active-low one-hot (digit 3 = MS nibble)
//   seg[6:0]    segment lines {A,B,C,D,E,F,G}, active-low
//   value[15:0] captured hex value, digit i in value[4i+3:4i]
//   dig_valid   per digit: last capture was a legal hex glyph
//   dig_err     per digit: last capture was a non-hex pattern
//   frame_done  one-cycle pulse when all four digits have been captured
//               since the previous pulse or reset
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int SETTLE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  anode,
    input  logic [6:0]  seg,
    output logic [15:0] value,
    output logic [3:0]  dig_valid,
    output logic [3:0]  dig_err,
    output logic        frame_done
);

    localparam logic [7:0] SETTLE_C  = 8'(SETTLE);
    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    logic [10:0] samp_d, samp_q;
    logic [7:0]  cnt_d, cnt_q;
    logic [3:0]  seen_d, seen_q;
    logic [15:0] value_d, value_q;
    logic [3:0]  valid_d, valid_q;
    logic [3:0]  err_d, err_q;
    logic        frame_d, frame_q;

    logic        legal;
    logic [1:0]  dig_idx;
    logic        glyph_ok;
    logic [3:0]  glyph_nib;
    logic        capture;
    logic [3:0]  seen_upd;

    // Exactly one anode low selects a digit; blank or multi-select is illegal.
    always_comb begin
        legal   = 1'b1;
        dig_idx = 2'd0;
        case (anode)
            4'b1110: dig_idx = 2'd0;
            4'b1101: dig_idx = 2'd1;
            4'b1011: dig_idx = 2'd2;
            4'b0111: dig_idx = 2'd3;
            default: legal   = 1'b0;
        endcase
    end

    // Inverse of the hex-to-segment table; anything else is an error glyph.
    always_comb begin
        glyph_ok  = 1'b1;
        glyph_nib = 4'h0;
        case (seg)
            7'b0000001: glyph_nib = 4'h0;
            7'b1001111: glyph_nib = 4'h1;
            7'b0010010: glyph_nib = 4'h2;
            7'b0000110: glyph_nib = 4'h3;
            7'b1001100: glyph_nib = 4'h4;
            7'b0100100: glyph_nib = 4'h5;
            7'b0100000: glyph_nib = 4'h6;
            7'b0001111: glyph_nib = 4'h7;
            7'b0000000: glyph_nib = 4'h8;
            7'b0001100: glyph_nib = 4'h9;
            7'b0001000: glyph_nib = 4'hA;
            7'b1100000: glyph_nib = 4'hB;
            7'b0110001: glyph_nib = 4'hC;
            7'b1000010: glyph_nib = 4'hD;
            7'b0110000: glyph_nib = 4'hE;
            7'b0111000: glyph_nib = 4'hF;
            default:    glyph_ok  = 1'b0;
        endcase
    end

    always_comb begin
        samp_d   = {anode, seg};
        cnt_d    = cnt_q;
        capture  = 1'b0;
        seen_d   = seen_q;
        seen_upd = seen_q;
        value_d  = value_q;
        valid_d  = valid_q;
        err_d    = err_q;
        frame_d  = 1'b0;

        // The incoming sample is compared against the one registered last
        // clock, so the first edge that sees a new pattern leaves the count at
        // 0 and the capture lands SETTLE edges later. Saturating at SETTLE
        // makes the SETTLE-1 -> SETTLE step happen once per stable window.
        if (!legal || (samp_d != samp_q)) begin
            cnt_d = 8'd0;
        end else if (cnt_q < SETTLE_C) begin
            cnt_d   = cnt_q + 8'd1;
            capture = (cnt_q == SETTLE_M1);
        end

        if (capture) begin
            if (glyph_ok) begin
                value_d[{dig_idx, 2'b00} +: 4] = glyph_nib;
                valid_d[dig_idx]               = 1'b1;
                err_d[dig_idx]                 = 1'b0;
            end else begin
                valid_d[dig_idx] = 1'b0;
                err_d[dig_idx]   = 1'b1;
            end
            seen_upd          = seen_q;
            seen_upd[dig_idx] = 1'b1;
            // Only the capture that completes the set pulses; the mask then
            // restarts so the next frame is tracked from scratch.
            if (seen_upd == 4'hF) begin
                frame_d = 1'b1;
                seen_d  = 4'h0;
            end else begin
                seen_d  = seen_upd;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_q  <= '0;
            cnt_q   <= '0;
            seen_q  <= '0;
            value_q <= '0;
            valid_q <= '0;
            err_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            samp_q  <= samp_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            value_q <= value_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            frame_q <= frame_d;
        end
    end

    assign value      = value_q;
    assign dig_valid  = valid_q;
    assign dig_err    = err_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

    localparam int SETTLE = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic [15:0] value;
    logic [3:0]  dig_valid;
    logic [3:0]  dig_err;
    logic        frame_done;

    seg7_scan_decoder #(.SETTLE(SETTLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .anode      (anode),
        .seg        (seg),
        .value      (value),
        .dig_valid  (dig_valid),
        .dig_err    (dig_err),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Segment patterns for each nibble, {A..G}, 0 = lit.
    localparam logic [6:0] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    localparam logic [6:0] SEG_ERR  = 7'b1001001;
    localparam logic [6:0] SEG_DARK = 7'b1111111;

    typedef struct {
        int          due;
        logic [15:0] v;
        logic [3:0]  dv;
        logic [3:0]  de;
        logic        fd;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state as of the last scheduled capture.
    logic [15:0] m_v    = '0;
    logic [3:0]  m_dv   = '0;
    logic [3:0]  m_de   = '0;
    logic [3:0]  m_seen = '0;

    // Outputs the DUT should be holding right now.
    logic [15:0] cur_v  = '0;
    logic [3:0]  cur_dv = '0;
    logic [3:0]  cur_de = '0;
    logic        exp_fd = 1'b0;

    task automatic drive(input logic [3:0] a, input logic [6:0] s);
        anode = a;
        seg   = s;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic expect_capture(input int due, input int d, input logic ok,
                                  input logic [3:0] nib);
        exp_t e;
        if (ok) begin
            m_v[d*4 +: 4] = nib;
            m_dv[d]       = 1'b1;
            m_de[d]       = 1'b0;
        end else begin
            m_dv[d] = 1'b0;
            m_de[d] = 1'b1;
        end
        m_seen[d] = 1'b1;
        e.fd = (m_seen == 4'hF);
        if (e.fd) m_seen = 4'h0;
        e.due = due;
        e.v   = m_v;
        e.dv  = m_dv;
        e.de  = m_de;
        sb.push_back(e);
    endtask

    function automatic logic [3:0] sel(input int d);
        logic [3:0] a;
        a    = 4'hF;
        a[d] = 1'b0;
        return a;
    endfunction

    task automatic model_clear();
        m_v = '0; m_dv = '0; m_de = '0; m_seen = '0;
        cur_v = '0; cur_dv = '0; cur_de = '0; exp_fd = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_clear();
        for (int i = 0; i < 6; i++) begin
            anode = 4'($urandom);
            seg   = 7'($urandom);
            @(posedge clk);
            cyc++;
            #1;
            checks++;
            if ({value, dig_valid, dig_err, frame_done} !== 25'd0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got v=%h dv=%b de=%b fd=%b want all zero",
                         cyc, value, dig_valid, dig_err, frame_done);
            end
        end
        #2 reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(4'hF, 7'($urandom));
            checks++;
            if ({value, dig_valid, dig_err, frame_done} !== 25'd0) begin
                errors++;
                $display("FAIL reset_blank cyc=%0d got v=%h dv=%b de=%b fd=%b want all zero",
                         cyc, value, dig_valid, dig_err, frame_done);
            end
        end
    endtask

    task automatic test_full_frame();
        logic [3:0] nibs [4];
        exp_t e;
        int pulses;
        nibs   = '{4'h1, 4'h2, 4'hA, 4'hF};
        pulses = 0;
        for (int d = 0; d < 4; d++) begin
            expect_capture(cyc + 1 + SETTLE, d, 1'b1, nibs[d]);
            for (int n = 0; n < 6; n++) begin
                drive(sel(d), GLYPH[nibs[d]]);
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    cur_v = e.v; cur_dv = e.dv; cur_de = e.de; exp_fd = e.fd;
                end else begin
                    exp_fd = 1'b0;
                end
                if (frame_done === 1'b1) pulses++;
                checks++;
                if ({value, dig_valid, dig_err, frame_done} !== {cur_v, cur_dv, cur_de, exp_fd}) begin
                    errors++;
                    $display("FAIL full_frame cyc=%0d got v=%h dv=%b de=%b fd=%b want v=%h dv=%b de=%b fd=%b",
                             cyc, value, dig_valid, dig_err, frame_done, cur_v, cur_dv, cur_de, exp_fd);
                end
            end
        end
        checks++;
        if (value !== 16'hFA21 || dig_valid !== 4'hF || dig_err !== 4'h0) begin
            errors++;
            $display("FAIL full_frame_final got v=%h dv=%b de=%b want v=fa21 dv=1111 de=0000",
                     value, dig_valid, dig_err);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL full_frame_pulses got %0d want 1", pulses);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL full_frame_pending got %0d entries want 0", sb.size());
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        for (int n = 0; n < 9; n++) begin
            if (n == 3) expect_capture(cyc + 1 + SETTLE, 0, 1'b1, 4'h1);
            drive(4'b1110, (n < 3) ? GLYPH[0] : GLYPH[1]);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                cur_v = e.v; cur_dv = e.dv; cur_de = e.de; exp_fd = e.fd;
            end else begin
                exp_fd = 1'b0;
            end
            checks++;
            if ({value, dig_valid, dig_err, frame_done} !== {cur_v, cur_dv, cur_de, exp_fd}) begin
                errors++;
                $display("FAIL glitch cyc=%0d got v=%h dv=%b de=%b fd=%b want v=%h dv=%b de=%b fd=%b",
                         cyc, value, dig_valid, dig_err, frame_done, cur_v, cur_dv, cur_de, exp_fd);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL glitch_pending got %0d entries want 0", sb.size());
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        // rows: multi-select hold, error glyph on digit 2, all-dark on digit 0
        for (int r = 0; r < 3; r++) begin
            if (r == 1) expect_capture(cyc + 1 + SETTLE, 2, 1'b0, 4'h0);
            if (r == 2) expect_capture(cyc + 1 + SETTLE, 0, 1'b0, 4'h0);
            for (int n = 0; n < ((r == 0) ? 10 : 6); n++) begin
                case (r)
                    0:       drive(4'b1100, GLYPH[8]);
                    1:       drive(4'b1011, SEG_ERR);
                    default: drive(4'b1110, SEG_DARK);
                endcase
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    cur_v = e.v; cur_dv = e.dv; cur_de = e.de; exp_fd = e.fd;
                end else begin
                    exp_fd = 1'b0;
                end
                checks++;
                if ({value, dig_valid, dig_err, frame_done} !== {cur_v, cur_dv, cur_de, exp_fd}) begin
                    errors++;
                    $display("FAIL illegal_%0d cyc=%0d got v=%h dv=%b de=%b fd=%b want v=%h dv=%b de=%b fd=%b",
                             r, cyc, value, dig_valid, dig_err, frame_done, cur_v, cur_dv, cur_de, exp_fd);
                end
            end
        end
        checks++;
        if (value[11:8] !== 4'hA || dig_err[2] !== 1'b1 || dig_valid[2] !== 1'b0) begin
            errors++;
            $display("FAIL illegal_digit2 got nib=%h err=%b valid=%b want nib=a err=1 valid=0",
                     value[11:8], dig_err[2], dig_valid[2]);
        end
    endtask

    task automatic test_hold_no_recapture();
        exp_t e;
        int pulses;
        pulses = 0;
        // digit 1 held long, then digit 3 completes the frame (digit 2 was an error capture)
        for (int r = 0; r < 2; r++) begin
            expect_capture(cyc + 1 + SETTLE, (r == 0) ? 1 : 3, 1'b1, (r == 0) ? 4'h7 : 4'hB);
            for (int n = 0; n < ((r == 0) ? 50 : 6); n++) begin
                if (r == 0) drive(4'b1101, GLYPH[7]);
                else        drive(4'b0111, GLYPH[11]);
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    cur_v = e.v; cur_dv = e.dv; cur_de = e.de; exp_fd = e.fd;
                end else begin
                    exp_fd = 1'b0;
                end
                if (frame_done === 1'b1) pulses++;
                checks++;
                if ({value, dig_valid, dig_err, frame_done} !== {cur_v, cur_dv, cur_de, exp_fd}) begin
                    errors++;
                    $display("FAIL hold_%0d cyc=%0d got v=%h dv=%b de=%b fd=%b want v=%h dv=%b de=%b fd=%b",
                             r, cyc, value, dig_valid, dig_err, frame_done, cur_v, cur_dv, cur_de, exp_fd);
                end
            end
            checks++;
            if (pulses != r) begin
                errors++;
                $display("FAIL hold_pulses_%0d got %0d want %0d", r, pulses, r);
            end
        end
        checks++;
        if (value !== 16'hBA71) begin
            errors++;
            $display("FAIL hold_final got v=%h want ba71", value);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive(4'b0111, GLYPH[5]);
        drive(4'b0111, GLYPH[5]);
        #2 reset = 1'b1;
        model_clear();
        #1;
        checks++;
        if ({value, dig_valid, dig_err, frame_done} !== 25'd0) begin
            errors++;
            $display("FAIL async_reset_immediate got v=%h dv=%b de=%b fd=%b want all zero",
                     value, dig_valid, dig_err, frame_done);
        end
        @(posedge clk);
        cyc++;
        #1;
        checks++;
        if ({value, dig_valid, dig_err, frame_done} !== 25'd0) begin
            errors++;
            $display("FAIL async_reset_held got v=%h dv=%b de=%b fd=%b want all zero",
                     value, dig_valid, dig_err, frame_done);
        end
        #2 reset = 1'b0;
        expect_capture(cyc + 1 + SETTLE, 3, 1'b1, 4'h5);
        for (int n = 0; n < 8; n++) begin
            drive(4'b0111, GLYPH[5]);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                cur_v = e.v; cur_dv = e.dv; cur_de = e.de; exp_fd = e.fd;
            end else begin
                exp_fd = 1'b0;
            end
            checks++;
            if ({value, dig_valid, dig_err, frame_done} !== {cur_v, cur_dv, cur_de, exp_fd}) begin
                errors++;
                $display("FAIL async_reset_recap cyc=%0d got v=%h dv=%b de=%b fd=%b want v=%h dv=%b de=%b fd=%b",
                         cyc, value, dig_valid, dig_err, frame_done, cur_v, cur_dv, cur_de, exp_fd);
            end
        end
        checks++;
        if (value !== 16'h5000 || dig_valid !== 4'b1000) begin
            errors++;
            $display("FAIL async_reset_final got v=%h dv=%b want v=5000 dv=1000", value, dig_valid);
        end
    endtask

    initial begin
        reset = 1'b1;
        anode = 4'hF;
        seg   = SEG_DARK;
        test_reset();
        test_full_frame();
        test_glitch();
        test_illegal();
        test_hold_no_recapture();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
